// File: rtl/ac_motor_pwm_decoder.sv
// Decodes one phase's PWM line over each carrier period delimited by the lock pulse,
// reporting high time, period length and the signed modulating value 2*high - period.
module ac_motor_pwm_decoder #(
    parameter int CNT_W    = 16,
    parameter int FILT_LEN = 3,
    parameter int TIMEOUT  = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pwm_in,
    input  logic             lock,
    output logic             sample_valid,
    output logic [CNT_W-1:0] high_count,
    output logic [CNT_W-1:0] period_count,
    output logic [CNT_W+1:0] value,
    output logic             pwm_filt,
    output logic             timeout
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_FAULT   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    logic sync1_q, sync2_q;
    logic pwm_filt_s;

    // Two-flop synchroniser for the asynchronous PWM line
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= pwm_in;
            sync2_q <= sync1_q;
        end
    end

    generate
        if (FILT_LEN == 0) begin : g_bypass
            assign pwm_filt_s = sync2_q;
        end else begin : g_filter
            localparam int RUN_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
            localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(FILT_LEN - 1);
            logic [RUN_W-1:0] run_q, run_d;
            logic             filt_q, filt_d;

            // Accept a new level only after it has persisted for FILT_LEN cycles
            always_comb begin
                filt_d = filt_q;
                run_d  = {RUN_W{1'b0}};
                if (sync2_q != filt_q) begin
                    if (run_q == RUN_LAST) begin
                        filt_d = sync2_q;
                        run_d  = {RUN_W{1'b0}};
                    end else begin
                        run_d = run_q + {{(RUN_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    run_d = {RUN_W{1'b0}};
                end
            end

            // Filter state registers
            always_ff @(posedge clk) begin
                if (reset) begin
                    filt_q <= 1'b0;
                    run_q  <= {RUN_W{1'b0}};
                end else begin
                    filt_q <= filt_d;
                    run_q  <= run_d;
                end
            end

            assign pwm_filt_s = filt_q;
        end
    endgenerate

    state_t           state_q, state_d;
    logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
    logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
    logic             sample_valid_q, sample_valid_d;
    logic [CNT_W-1:0] high_count_q, high_count_d;
    logic [CNT_W-1:0] period_count_q, period_count_d;
    logic [CNT_W+1:0] value_q, value_d;
    logic             timeout_q, timeout_d;
    logic             latch_s;

    // Window FSM, saturating counters and result latch
    always_comb begin
        state_d        = state_q;
        high_cnt_d     = high_cnt_q;
        period_cnt_d   = period_cnt_q;
        latch_s        = 1'b0;
        case (state_q)
            ST_IDLE, ST_FAULT: begin
                high_cnt_d   = {CNT_W{1'b0}};
                period_cnt_d = {CNT_W{1'b0}};
                if (lock) begin
                    // The lock cycle itself is the first cycle of the new window
                    state_d      = ST_MEASURE;
                    high_cnt_d   = {{(CNT_W-1){1'b0}}, pwm_filt_s};
                    period_cnt_d = CNT_ONE;
                end else begin
                    state_d = state_q;
                end
            end
            ST_MEASURE: begin
                if (lock) begin
                    latch_s      = 1'b1;
                    high_cnt_d   = {{(CNT_W-1){1'b0}}, pwm_filt_s};
                    period_cnt_d = CNT_ONE;
                end else if (period_cnt_q >= TO_LAST) begin
                    state_d      = ST_FAULT;
                    high_cnt_d   = {CNT_W{1'b0}};
                    period_cnt_d = {CNT_W{1'b0}};
                end else begin
                    if (period_cnt_q == CNT_MAX) begin
                        period_cnt_d = period_cnt_q;
                    end else begin
                        period_cnt_d = period_cnt_q + CNT_ONE;
                    end
                    if (pwm_filt_s && (high_cnt_q != CNT_MAX)) begin
                        high_cnt_d = high_cnt_q + CNT_ONE;
                    end else begin
                        high_cnt_d = high_cnt_q;
                    end
                end
            end
            default: begin
                state_d      = ST_IDLE;
                high_cnt_d   = {CNT_W{1'b0}};
                period_cnt_d = {CNT_W{1'b0}};
            end
        endcase

        sample_valid_d = latch_s;
        timeout_d      = (state_d == ST_FAULT);
        if (latch_s) begin
            high_count_d   = high_cnt_q;
            period_count_d = period_cnt_q;
            value_d        = {1'b0, high_cnt_q, 1'b0} - {2'b00, period_cnt_q};
        end else begin
            high_count_d   = high_count_q;
            period_count_d = period_count_q;
            value_d        = value_q;
        end
    end

    // State, counter and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            high_cnt_q     <= {CNT_W{1'b0}};
            period_cnt_q   <= {CNT_W{1'b0}};
            sample_valid_q <= 1'b0;
            high_count_q   <= {CNT_W{1'b0}};
            period_count_q <= {CNT_W{1'b0}};
            value_q        <= {(CNT_W+2){1'b0}};
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            high_cnt_q     <= high_cnt_d;
            period_cnt_q   <= period_cnt_d;
            sample_valid_q <= sample_valid_d;
            high_count_q   <= high_count_d;
            period_count_q <= period_count_d;
            value_q        <= value_d;
            timeout_q      <= timeout_d;
        end
    end

    assign sample_valid = sample_valid_q;
    assign high_count   = high_count_q;
    assign period_count = period_count_q;
    assign value        = value_q;
    assign pwm_filt     = pwm_filt_s;
    assign timeout      = timeout_q;

endmodule
